// File: rtl/ahb_slave_arbiter_if.sv
// Bus bundle between the masters' request side and one slave's round-robin arbiter.
// The arbiter takes the slave modport; the requesting side takes the master modport.
interface ahb_slave_arbiter_if #(
  parameter int unsigned CHANNEL_NUM = 2,
  parameter int unsigned ID_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
);
  logic [CHANNEL_NUM-1:0]      req;
  logic [CHANNEL_NUM-1:0][1:0] htrans_in;
  logic [CHANNEL_NUM-1:0][2:0] hburst_in;
  logic                        hready;
  logic [CHANNEL_NUM-1:0]      grant;
  logic [CHANNEL_NUM-1:0]      grant_data;
  logic [ID_W-1:0]             grant_id;
  logic                        busy;

  modport master (
    output req, htrans_in, hburst_in, hready,
    input  grant, grant_data, grant_id, busy
  );

  modport slave (
    input  req, htrans_in, hburst_in, hready,
    output grant, grant_data, grant_id, busy
  );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin arbiter. It holds the grant across AHB bursts and produces a
// data-phase-delayed copy of the grant for the response and write-data path.
module ahb_slave_arbiter #(
  parameter int unsigned CHANNEL_NUM = 2,
  parameter int unsigned ID_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_slave_arbiter_if.slave bus
);
  localparam logic [1:0] TrIdle   = 2'd0;
  localparam logic [1:0] TrBusy   = 2'd1;
  localparam logic [1:0] TrNonseq = 2'd2;
  localparam logic [1:0] TrSeq    = 2'd3;

  typedef enum logic [1:0] {StIdle, StOwn, StBurst} state_e;

  state_e                 state_q, state_d;
  logic [CHANNEL_NUM-1:0] grant_q, grant_d;
  logic [CHANNEL_NUM-1:0] grant_data_q, grant_data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;
  logic                   incr_q, incr_d;
  logic                   busy_q, busy_d;

  logic                   arb_found;
  logic [ID_W-1:0]        arb_id;
  logic [1:0]             own_trans;
  logic [2:0]             own_burst;
  logic                   own_req;
  logic                   rel;
  logic                   start;

  assign own_trans = bus.htrans_in[grant_id_q];
  assign own_burst = bus.hburst_in[grant_id_q];
  assign own_req   = bus.req[grant_id_q];

  // Scan starts just after the last winner, so the current owner is checked last.
  always_comb begin
    int unsigned idx;
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
      idx = (32'(rr_ptr_q) + k) % CHANNEL_NUM;
      if (!arb_found && bus.req[idx]) begin
        arb_found = 1'b1;
        arb_id    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_data_d = grant_data_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    incr_d       = incr_q;
    busy_d       = busy_q;
    rel          = 1'b0;
    start        = 1'b0;

    if (bus.hready) begin
      grant_data_d = grant_q;

      unique case (state_q)
        StIdle: rel = 1'b1;
        StOwn: begin
          if (own_trans == TrNonseq) start = 1'b1;
          else if (own_trans == TrIdle && !own_req) rel = 1'b1;
        end
        StBurst: begin
          if (own_trans == TrIdle) begin
            rel = 1'b1;
          end else if (own_trans == TrNonseq) begin
            // An undefined-length burst whose master has gone away ends here.
            if (incr_q && !own_req) rel = 1'b1;
            else start = 1'b1;
          end else if (own_trans == TrSeq && !incr_q) begin
            if (beat_cnt_q == 4'd1) rel = 1'b1;
            else beat_cnt_d = beat_cnt_q - 4'd1;
          end
        end
        default: rel = 1'b1;
      endcase

      if (start) begin
        state_d = StBurst;
        incr_d  = 1'b0;
        unique case (own_burst)
          3'd0:       rel = 1'b1;
          3'd1:       incr_d = 1'b1;
          3'd2, 3'd3: beat_cnt_d = 4'd3;
          3'd4, 3'd5: beat_cnt_d = 4'd7;
          default:    beat_cnt_d = 4'd15;
        endcase
      end

      if (rel) begin
        beat_cnt_d = '0;
        incr_d     = 1'b0;
        grant_d    = '0;
        if (arb_found) begin
          grant_d[arb_id] = 1'b1;
          grant_id_d      = arb_id;
          rr_ptr_d        = arb_id;
          busy_d          = 1'b1;
          state_d         = StOwn;
        end else begin
          grant_id_d = '0;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      grant_data_q <= '0;
      grant_id_q   <= '0;
      rr_ptr_q     <= ID_W'(CHANNEL_NUM - 1);
      beat_cnt_q   <= '0;
      incr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_data_q <= grant_data_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      incr_q       <= incr_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_data = grant_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: directed burst scenarios followed by random traffic,
// all checked against a transaction-level model of owner, priority and burst progress.
module tb_ahb_slave_arbiter;
  localparam int unsigned CN  = 2;
  localparam int unsigned IDW = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_slave_arbiter_if #(.CHANNEL_NUM(CN), .ID_W(IDW)) bus ();

  ahb_slave_arbiter #(.CHANNEL_NUM(CN), .ID_W(IDW)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner index (-1 = none), last winner, burst length in beats
  // (0 = no burst, -1 = undefined INCR) and beats accepted so far.
  int          m_owner;
  int          m_rr;
  int          m_blen;
  int          m_bdone;
  logic [CN-1:0] m_gdata;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [CN-1:0] onehot(input int o);
    logic [CN-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr    = CN - 1;
    m_blen  = 0;
    m_bdone = 0;
    m_gdata = '0;
  endtask

  task automatic model_release();
    int w;
    w = -1;
    for (int k = 1; k <= CN; k++) begin
      if (w < 0 && bus.req[(m_rr + k) % CN]) w = (m_rr + k) % CN;
    end
    m_owner = w;
    if (w >= 0) m_rr = w;
    m_blen  = 0;
    m_bdone = 0;
  endtask

  task automatic model_start(input int b);
    if (b == 0) begin
      model_release();
    end else if (b == 1) begin
      m_blen  = -1;
      m_bdone = 1;
    end else begin
      m_blen  = 4 << ((b - 2) / 2);
      m_bdone = 1;
    end
  endtask

  task automatic model_edge();
    int t, b, r;
    if (!bus.hready) return;
    m_gdata = onehot(m_owner);
    if (m_owner < 0) begin
      model_release();
      return;
    end
    t = int'(bus.htrans_in[m_owner]);
    b = int'(bus.hburst_in[m_owner]);
    r = int'(bus.req[m_owner]);
    if (m_blen == 0) begin
      if (t == 2) model_start(b);
      else if (t == 0 && r == 0) model_release();
    end else begin
      if (t == 0) model_release();
      else if (t == 2) begin
        if (m_blen < 0 && r == 0) model_release();
        else model_start(b);
      end else if (t == 3 && m_blen > 0) begin
        m_bdone++;
        if (m_bdone == m_blen) model_release();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".grant"}, 32'(bus.grant), 32'(onehot(m_owner)));
    check_eq({tag, ".grant_data"}, 32'(bus.grant_data), 32'(m_gdata));
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
    if (m_owner >= 0) check_eq({tag, ".grant_id"}, 32'(bus.grant_id), 32'(m_owner));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] t0, input logic [2:0] b0,
                       input logic [1:0] t1, input logic [2:0] b1, input logic hr);
    bus.req          = rq;
    bus.htrans_in[0] = t0;
    bus.hburst_in[0] = b0;
    bus.htrans_in[1] = t1;
    bus.hburst_in[1] = b1;
    bus.hready       = hr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(2'b11, 2'd0, 3'd0, 2'd0, 3'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    cycle("rst_release");

    // Round robin with SINGLE transfers
    do_reset();
    drive(2'b11, 2'd2, 3'd0, 2'd2, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("rr_single");

    // INCR4 hold on m0 while m1 requests
    do_reset();
    drive(2'b11, 2'd0, 3'd0, 2'd2, 3'd0, 1'b1);
    cycle("incr4_own");
    drive(2'b11, 2'd2, 3'd3, 2'd2, 3'd0, 1'b1);
    cycle("incr4_b1");
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'd3, 3'd3, 2'd2, 3'd0, 1'b1);
      cycle("incr4_seq");
    end

    // Same burst with wait states and a BUSY
    do_reset();
    drive(2'b11, 2'd0, 3'd0, 2'd2, 3'd0, 1'b1);
    cycle("ws_own");
    drive(2'b11, 2'd2, 3'd3, 2'd2, 3'd0, 1'b1);
    cycle("ws_b1");
    drive(2'b11, 2'd3, 3'd3, 2'd2, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ws_wait");
    drive(2'b11, 2'd3, 3'd3, 2'd2, 3'd0, 1'b1);
    cycle("ws_b2");
    drive(2'b11, 2'd1, 3'd3, 2'd2, 3'd0, 1'b1);
    cycle("ws_busy");
    drive(2'b11, 2'd3, 3'd3, 2'd2, 3'd0, 1'b1);
    cycle("ws_b3");
    cycle("ws_b4");
    cycle("ws_after");

    // Undefined-length INCR on m1
    do_reset();
    drive(2'b10, 2'd0, 3'd0, 2'd0, 3'd1, 1'b1);
    cycle("incr_own");
    drive(2'b11, 2'd2, 3'd0, 2'd2, 3'd1, 1'b1);
    cycle("incr_b1");
    drive(2'b11, 2'd2, 3'd0, 2'd3, 3'd1, 1'b1);
    for (int i = 0; i < 6; i++) cycle("incr_seq");
    drive(2'b11, 2'd2, 3'd0, 2'd0, 3'd1, 1'b1);
    cycle("incr_idle");

    // Async reset in the middle of a WRAP8
    do_reset();
    drive(2'b11, 2'd0, 3'd0, 2'd2, 3'd0, 1'b1);
    cycle("wrap8_own");
    drive(2'b11, 2'd2, 3'd4, 2'd2, 3'd0, 1'b1);
    cycle("wrap8_b1");
    drive(2'b11, 2'd3, 3'd4, 2'd2, 3'd0, 1'b1);
    cycle("wrap8_b2");
    cycle("wrap8_b3");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst.grant", 32'(bus.grant), 32'd0);
    check_eq("async_rst.grant_data", 32'(bus.grant_data), 32'd0);
    check_eq("async_rst.busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] tr [CN];
      for (int c = 0; c < CN; c++) begin
        int r;
        r = int'($urandom_range(0, 9));
        tr[c] = (r < 2) ? 2'd0 : (r == 2) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
      end
      drive(2'($urandom_range(0, 3)), tr[0], 3'($urandom_range(0, 7)),
            tr[1], 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 8);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
